// File: rtl/data_mem_responder_pkg.sv
// Shared types and constants for the data-memory responder and its byte-merge helper.
package data_mem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } mem_resp_state_e;

  localparam logic [63:0] DEFAULT_TOHOST_ADDR = 64'h0000_0000_0000_1000;

  typedef struct packed {
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  byte_en;
    logic        wen;
  } mem_req_t;

endpackage

// File: rtl/data_mem_responder_if.sv
// Request/response bus between the core's data-memory adapter and the responder.
interface data_mem_responder_if;

  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [7:0]  req_byte_en;
  logic        req_wen;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_addr, req_wdata, req_byte_en, req_wen,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_addr, req_wdata, req_byte_en, req_wen,
    output req_ready, resp_valid, resp_rdata, resp_err
  );

endinterface

// File: rtl/data_mem_responder_byte_merge.sv
// Per-lane byte merge of new write data into an existing 64-bit word.
module mem_byte_merge (
  input  logic [63:0] i_old,
  input  logic [63:0] i_wdata,
  input  logic [7:0]  i_byte_en,
  output logic [63:0] o_merged
);

  always_comb begin
    o_merged = i_old;
    for (int i = 0; i < 8; i++) begin
      if (i_byte_en[i]) o_merged[8*i +: 8] = i_wdata[8*i +: 8];
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Word-organised data memory with fixed-latency responses and a sticky tohost MMIO word.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int          DEPTH_WORDS = 4096,
  parameter int          LATENCY     = 1,
  parameter logic [63:0] TOHOST_ADDR = DEFAULT_TOHOST_ADDR
) (
  input  logic                 clk,
  input  logic                 rst,
  data_mem_responder_if.slave  bus,
  output logic                 tohost_valid,
  output logic [63:0]          tohost_data
);

  localparam int         IDX_W  = $clog2(DEPTH_WORDS);
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  mem_resp_state_e r_state;
  logic [3:0]      r_cnt;
  logic [63:0]     r_mem [DEPTH_WORDS];
  logic            r_resp_valid;
  logic [63:0]     r_resp_rdata;
  logic            r_resp_err;
  logic            r_tohost_valid;
  logic [63:0]     r_tohost_data;

  mem_req_t    w_req;
  logic        w_accept;
  logic        w_is_tohost;
  logic        w_in_range;
  logic [IDX_W-1:0] w_idx;
  logic [63:0] w_old;
  logic [63:0] w_merged;

  assign w_req.addr    = bus.req_addr;
  assign w_req.wdata   = bus.req_wdata;
  assign w_req.byte_en = bus.req_byte_en;
  assign w_req.wen     = bus.req_wen;

  assign w_accept    = (r_state == IDLE) && bus.req_valid;
  // tohost is decoded first so it never aliases into storage even when in range
  assign w_is_tohost = (w_req.addr == TOHOST_ADDR);
  assign w_in_range  = (w_req.addr >> 3) < 64'(DEPTH_WORDS);
  assign w_idx       = w_req.addr[3 +: IDX_W];
  assign w_old       = w_is_tohost ? r_tohost_data : r_mem[w_idx];

  mem_byte_merge u_merge (
    .i_old     (w_old),
    .i_wdata   (w_req.wdata),
    .i_byte_en (w_req.byte_en),
    .o_merged  (w_merged)
  );

  assign bus.req_ready  = (r_state == IDLE);
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_rdata = r_resp_rdata;
  assign bus.resp_err   = r_resp_err;
  assign tohost_valid   = r_tohost_valid;
  assign tohost_data    = r_tohost_data;

  // Storage is never cleared; a write commits at its accept edge
  always_ff @(posedge clk) begin
    if (!rst && w_accept && w_req.wen && !w_is_tohost && w_in_range)
      r_mem[w_idx] <= w_merged;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= IDLE;
      r_cnt          <= '0;
      r_resp_valid   <= 1'b0;
      r_resp_rdata   <= '0;
      r_resp_err     <= 1'b0;
      r_tohost_valid <= 1'b0;
      r_tohost_data  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.req_valid) begin
            r_cnt        <= LAT_M1;
            r_state      <= (LATENCY > 1) ? WAIT : RESP;
            r_resp_valid <= (LATENCY == 1);
            r_resp_err   <= !w_is_tohost && !w_in_range;
            if (w_req.wen)
              r_resp_rdata <= '0;
            else if (w_is_tohost)
              r_resp_rdata <= r_tohost_data;
            else if (w_in_range)
              r_resp_rdata <= r_mem[w_idx];
            else
              r_resp_rdata <= '0;
            if (w_req.wen && w_is_tohost && !r_tohost_valid && (w_merged != '0)) begin
              r_tohost_valid <= 1'b1;
              r_tohost_data  <= w_merged;
            end
          end
        end
        WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            r_state      <= RESP;
            r_resp_valid <= 1'b1;
          end
        end
        RESP: begin
          r_state      <= IDLE;
          r_resp_valid <= 1'b0;
          r_resp_rdata <= '0;
          r_resp_err   <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed-vector bench for data_mem_responder at LATENCY=1 and LATENCY=4.
module tb_data_mem_responder;

  logic        clk;
  logic        rst1, rst4;
  logic        th_valid1, th_valid4;
  logic [63:0] th_data1, th_data4;
  int          n_vec, n_err;

  data_mem_responder_if if1();
  data_mem_responder_if if4();
  virtual data_mem_responder_if vif;

  data_mem_responder #(.DEPTH_WORDS(4096), .LATENCY(1), .TOHOST_ADDR(64'h1000)) u_l1 (
    .clk(clk), .rst(rst1), .bus(if1.slave), .tohost_valid(th_valid1), .tohost_data(th_data1)
  );

  data_mem_responder #(.DEPTH_WORDS(4096), .LATENCY(4), .TOHOST_ADDR(64'h1000)) u_l4 (
    .clk(clk), .rst(rst4), .bus(if4.slave), .tohost_valid(th_valid4), .tohost_data(th_data4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One transaction on vif; returns response fields and measured latency in cycles.
  task automatic do_req(input logic wen, input logic [63:0] addr, input logic [63:0] wdata,
                        input logic [7:0] be, output logic [63:0] rdata, output logic err,
                        output int lat);
    int k;
    vif.req_wen     = wen;
    vif.req_addr    = addr;
    vif.req_wdata   = wdata;
    vif.req_byte_en = be;
    vif.req_valid   = 1'b1;
    k = 0;
    while (!vif.req_ready && k < 20) begin
      @(posedge clk); #1; k++;
    end
    @(posedge clk); #1;
    vif.req_valid = 1'b0;
    k = 1;
    while (!vif.resp_valid && k < 20) begin
      @(posedge clk); #1; k++;
    end
    rdata = vif.resp_rdata;
    err   = vif.resp_err;
    lat   = k;
    if (!vif.resp_valid) begin
      check_vec("resp_timeout", 64'(vif.resp_valid), 64'd1);
    end else begin
      check_vec("ready_in_resp", 64'(vif.req_ready), 64'd0);
      @(posedge clk); #1;
      check_vec("resp_one_cycle", 64'(vif.resp_valid), 64'd0);
    end
  endtask

  logic [63:0] rd;
  logic        er;
  int          lat;
  int          acc[4], rsp[4];
  int          na, nr;
  logic        bad, seen;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec = 0; n_err = 0;
    rst1 = 1'b1; rst4 = 1'b1;
    if1.req_valid = 0; if1.req_addr = 0; if1.req_wdata = 0; if1.req_byte_en = 0; if1.req_wen = 0;
    if4.req_valid = 0; if4.req_addr = 0; if4.req_wdata = 0; if4.req_byte_en = 0; if4.req_wen = 0;
    repeat (3) @(posedge clk);
    #1;
    rst1 = 1'b0; rst4 = 1'b0;

    check_vec("rst_resp_valid", 64'(if1.resp_valid), 64'd0);
    check_vec("rst_resp_rdata", if1.resp_rdata, 64'd0);
    check_vec("rst_resp_err", 64'(if1.resp_err), 64'd0);
    check_vec("rst_tohost_valid", 64'(th_valid1), 64'd0);
    check_vec("rst_tohost_data", th_data1, 64'd0);
    check_vec("rst_req_ready", 64'(if1.req_ready), 64'd1);

    vif = if1;
    do_req(1'b1, 64'h40, 64'h1122334455667788, 8'hFF, rd, er, lat);
    check_vec("l1_wr_lat", 64'(lat), 64'd1);
    check_vec("l1_wr_rdata", rd, 64'd0);
    check_vec("l1_wr_err", 64'(er), 64'd0);
    do_req(1'b0, 64'h40, 64'h0, 8'h00, rd, er, lat);
    check_vec("l1_rd_lat", 64'(lat), 64'd1);
    check_vec("l1_rd_data", rd, 64'h1122334455667788);

    do_req(1'b1, 64'h40, 64'hAAAAAAAABBBBBBBB, 8'h0F, rd, er, lat);
    do_req(1'b0, 64'h40, 64'h0, 8'h00, rd, er, lat);
    check_vec("partial_rd", rd, 64'h11223344BBBBBBBB);

    do_req(1'b1, 64'h40, 64'hFFFFFFFFFFFFFFFF, 8'h00, rd, er, lat);
    check_vec("be0_resp_lat", 64'(lat), 64'd1);
    do_req(1'b0, 64'h40, 64'h0, 8'h00, rd, er, lat);
    check_vec("be0_noop_rd", rd, 64'h11223344BBBBBBBB);

    do_req(1'b1, 64'h7FF8, 64'h0BADF00D12345678, 8'hFF, rd, er, lat);
    check_vec("top_word_wr_err", 64'(er), 64'd0);
    do_req(1'b0, 64'h7FF8, 64'h0, 8'h00, rd, er, lat);
    check_vec("top_word_rd", rd, 64'h0BADF00D12345678);

    do_req(1'b1, 64'h0, 64'hCAFEBABEDEADBEEF, 8'hFF, rd, er, lat);
    do_req(1'b1, 64'h8000, 64'h5555555555555555, 8'hFF, rd, er, lat);
    check_vec("oor_wr_err", 64'(er), 64'd1);
    check_vec("oor_wr_rdata", rd, 64'd0);
    do_req(1'b0, 64'h8000, 64'h0, 8'h00, rd, er, lat);
    check_vec("oor_rd_err", 64'(er), 64'd1);
    check_vec("oor_rd_rdata", rd, 64'd0);
    do_req(1'b0, 64'h0, 64'h0, 8'h00, rd, er, lat);
    check_vec("oor_spot_0", rd, 64'hCAFEBABEDEADBEEF);
    check_vec("inr_rd_err", 64'(er), 64'd0);

    do_req(1'b1, 64'h1000, 64'h0, 8'hFF, rd, er, lat);
    check_vec("th_zero_valid", 64'(th_valid1), 64'd0);
    do_req(1'b1, 64'h1000, 64'h1, 8'hFF, rd, er, lat);
    check_vec("th_one_valid", 64'(th_valid1), 64'd1);
    check_vec("th_one_data", th_data1, 64'd1);
    check_vec("th_wr_err", 64'(er), 64'd0);
    do_req(1'b1, 64'h1000, 64'h5, 8'hFF, rd, er, lat);
    check_vec("th_sticky_data", th_data1, 64'd1);
    do_req(1'b0, 64'h1000, 64'h0, 8'h00, rd, er, lat);
    check_vec("th_rd", rd, 64'd1);

    vif = if4;
    do_req(1'b1, 64'h80, 64'h0123456789ABCDEF, 8'hFF, rd, er, lat);
    check_vec("l4_wr_lat", 64'(lat), 64'd4);
    do_req(1'b0, 64'h80, 64'h0, 8'h00, rd, er, lat);
    check_vec("l4_rd_lat", 64'(lat), 64'd4);
    check_vec("l4_rd_data", rd, 64'h0123456789ABCDEF);

    // req_valid held high across several back-to-back transactions
    na = 0; nr = 0; bad = 1'b0;
    if4.req_wen = 1'b0; if4.req_addr = 64'h80; if4.req_valid = 1'b1;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (if4.req_ready) begin
        if (na < 4) acc[na] = c;
        na++;
      end
      if (if4.resp_valid) begin
        if (nr < 4) rsp[nr] = c;
        nr++;
        if (if4.req_ready) bad = 1'b1;
      end
    end
    if4.req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_vec("held_accepts", 64'(na), 64'd3);
    check_vec("held_resps", 64'(nr), 64'd2);
    check_vec("held_ready_busy", 64'(bad), 64'd0);
    if (na >= 3 && nr >= 2) begin
      check_vec("held_acc_gap0", 64'(acc[1] - acc[0]), 64'd5);
      check_vec("held_acc_gap1", 64'(acc[2] - acc[1]), 64'd5);
      check_vec("held_resp_lat0", 64'(rsp[0] - acc[0]), 64'd4);
      check_vec("held_resp_lat1", 64'(rsp[1] - acc[1]), 64'd4);
    end

    do_req(1'b1, 64'h1000, 64'h1, 8'hFF, rd, er, lat);
    check_vec("l4_th_set", 64'(th_valid4), 64'd1);

    // Reset two cycles into a read
    if4.req_wen = 1'b0; if4.req_addr = 64'h80; if4.req_valid = 1'b1;
    @(posedge clk); #1;
    if4.req_valid = 1'b0;
    seen = if4.resp_valid;
    @(posedge clk); #1;
    seen = seen | if4.resp_valid;
    rst4 = 1'b1;
    @(posedge clk); #1;
    seen = seen | if4.resp_valid;
    rst4 = 1'b0;
    check_vec("rst_mid_ready", 64'(if4.req_ready), 64'd1);
    check_vec("rst_mid_tohost", 64'(th_valid4), 64'd0);
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      seen = seen | if4.resp_valid;
    end
    check_vec("rst_mid_no_resp", 64'(seen), 64'd0);
    do_req(1'b0, 64'h80, 64'h0, 8'h00, rd, er, lat);
    check_vec("rst_mid_data_kept", rd, 64'h0123456789ABCDEF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
Memory-side responder for the core's data-memory port. It serves byte-enabled 64-bit read/write requests from a word-organised storage array. Requests use a valid/ready handshake, and each request gets one response after a programmable latency. A tohost MMIO word signals end-of-test to the bench. It sits between processor_top's data-memory interface (via a request adapter) and the simulation/FPGA top.

Parameters:
DEPTH_WORDS, 4096, number of 64-bit words in storage; power of 2, minimum 2
LATENCY, 1, cycles from request acceptance to resp_valid; legal range 1..15
TOHOST_ADDR, 64'h0000_0000_0000_1000, byte address of the tohost MMIO word; must be 8-byte aligned

Ports:
clk  input  1  system clock
rst  input  1  reset, synchronous, active-high
req_valid  input  1  request present
req_ready  output  1  responder can accept a request this cycle
req_addr  input  64  byte address; bits [2:0] ignored (lane selected by req_byte_en)
req_wdata  input  64  write data, lane-aligned
req_byte_en  input  8  byte-lane enables for writes; ignored for reads
req_wen  input  1  1 = write, 0 = read
resp_valid  output  1  one-cycle response strobe
resp_rdata  output  64  full 64-bit word read; 0 for writes and errors
resp_err  output  1  address out of range; valid only with resp_valid
tohost_valid  output  1  sticky; set by a nonzero write to TOHOST_ADDR
tohost_data  output  64  value of the first nonzero tohost write

Behaviour:
- Reset (rst=1 at clk edge):
  - state=IDLE, counter=0.
  - resp_valid=0, resp_rdata=0, resp_err=0, tohost_valid=0, tohost_data=0.
  - Storage contents are NOT cleared.
  - Reset mid-transaction abandons the transaction with no response. A write already committed stays committed.
- FSM states:
  - IDLE: req_ready=1. On req_valid, the request is accepted at that edge. Go to WAIT if LATENCY>1, else RESP. Counter loads LATENCY-1.
  - WAIT: req_ready=0. Counter decrements each cycle; on reaching 1, go to RESP.
  - RESP: req_ready=0, resp_valid=1 for exactly one cycle, then IDLE. There is no response backpressure.
- Throughput: at most one outstanding request; one request per LATENCY+1 cycles. Response arrives exactly LATENCY cycles after the accept edge.
- Index and range:
  - index = req_addr[3 +: log2(DEPTH_WORDS)].
  - In range iff req_addr >> 3 < DEPTH_WORDS, or req_addr == TOHOST_ADDR.
  - TOHOST_ADDR is decoded before the range check and never touches storage.
- Writes:
  - Commit at the accept edge with per-lane merge: new[8i+7:8i] = byte_en[i] ? wdata : old.
  - byte_en=0 is a legal no-op and still produces a response.
  - Write response: resp_rdata=0, resp_err=0.
- Reads:
  - The word is captured into the response register at the accept edge and held until RESP.
  - A read of TOHOST_ADDR returns tohost_data.
- Out of range: write dropped, resp_rdata=0, resp_err=1.
- Tohost:
  - A write to TOHOST_ADDR with nonzero merged data while tohost_valid=0 sets tohost_valid and loads tohost_data.
  - Once set, later writes are ignored until rst.
  - A zero write has no effect.
- Simultaneous events: req_valid during WAIT/RESP is ignored. The requester must hold req_valid, so no request is lost.
- Outputs are registered except req_ready, which is decoded from state.

Decomposition:
- riscv_pkg additions: mem_resp_state_e enum {IDLE, WAIT, RESP}; DEFAULT_TOHOST_ADDR constant; mem_req_t struct {addr, wdata, byte_en, wen}.
- One sub-module: mem_byte_merge, combinational. Inputs: old word, wdata, byte_en. Output: merged word. Reused later by the cache fill path.
- FSM and storage live in data_mem_responder.

Test Plan:
- LATENCY=1: write addr 0x40, wdata 0x1122334455667788, byte_en 0xFF; then read 0x40. Required: each resp_valid exactly 1 cycle after accept; read data 0x1122334455667788; req_ready low during RESP.
- Partial write: byte_en 0x0F, wdata 0xAAAAAAAABBBBBBBB to 0x40 (prior value 0x1122334455667788). Required: read returns 0x11223344BBBBBBBB.
- LATENCY=4, req_valid held high continuously. Required:
  - resp_valid at accept+4; next accept 5 cycles after the previous one.
  - No double accept; req_valid ignored while busy.
- Out of range with DEPTH_WORDS=4096: write to 0x8000, then read 0x8000. Required: both resp_err=1, rdata=0, storage unchanged (spot-check 0x0).
- Tohost:
  - Write 0 to 0x1000: tohost_valid stays 0.
  - Write 0x1: tohost_valid=1, tohost_data=1.
  - Write 0x5: tohost_data stays 1.
  - Read 0x1000: returns 1.
- Reset mid-WAIT (LATENCY=4, rst asserted 2 cycles after a read accept). Required: no resp_valid; req_ready=1 in the first cycle after rst deasserts; tohost_valid=0; prior stored data intact.
